uart_tx_arbiter: RTL

- Round-robin scheduler that shares one byte-wide UART transmitter among NUM_REQ independent byte sources.
- Sits between the requesters (switch logic, status reporters, debug dumpers) and the transmitter's start/data/busy interface.
- Issues exactly one single-cycle start pulse per byte and waits for the frame to finish before it grants again.
- Detects a transmitter that never goes busy and reports it.

---
 rtl/uart_tx_arbiter_if.sv | 22 ++
 rtl/uart_tx_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for the UART transmit arbiter.
// The master modport is the arbiter's view; slave is the requesters/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;

  modport master (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_start, tx_data
  );

  modport slave (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one byte-wide UART transmitter among NUM_REQ sources.
// One start pulse per byte, waits for the frame to end, flags a transmitter that never goes busy.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int IDW           = 2,
  parameter int START_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_arbiter_if.master    bus,
  output logic [IDW-1:0]       grant_id,
  output logic                 active,
  output logic                 timeout_err,
  output logic [15:0]          byte_count
);

  localparam int CW = $clog2(START_TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

  state_t             state;
  logic [CW-1:0]      toCnt;

  logic               found;
  logic [IDW-1:0]     winner;
  logic [7:0]         winData;
  logic [NUM_REQ-1:0] winHot;

  // Search above the last winner first, then wrap; the last winner ends up lowest priority.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    found   = 1'b0;
    winner  = grant_id;
    winData = 8'h00;
    winHot  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && i > int'(grant_id) && bus.req_valid[i]) begin
        found     = 1'b1;
        winner    = IDW'(i);
        winData   = bus.req_data[8*i +: 8];
        winHot[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && i <= int'(grant_id) && bus.req_valid[i]) begin
        found     = 1'b1;
        winner    = IDW'(i);
        winData   = bus.req_data[8*i +: 8];
        winHot[i] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      toCnt         <= '0;
      bus.req_ready <= '0;
      bus.tx_start  <= 1'b0;
      bus.tx_data   <= 8'h00;
      grant_id      <= IDW'(NUM_REQ - 1);
      active        <= 1'b0;
      timeout_err   <= 1'b0;
      byte_count    <= 16'h0000;
    end else begin
      bus.req_ready <= '0;
      bus.tx_start  <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.tx_busy && found) begin
            bus.tx_start  <= 1'b1;
            bus.tx_data   <= winData;
            bus.req_ready <= winHot;
            grant_id      <= winner;
            active        <= 1'b1;
            toCnt         <= '0;
            state         <= START;
          end
        end
        START: begin
          if (bus.tx_busy) begin
            state <= BUSY;
          end else if (toCnt == CW'(START_TIMEOUT - 1)) begin
            // Byte is dropped: it was already acknowledged and is not counted.
            timeout_err <= 1'b1;
            active      <= 1'b0;
            state       <= IDLE;
          end else begin
            toCnt <= toCnt + 1'b1;
          end
        end
        BUSY: begin
          if (!bus.tx_busy) begin
            byte_count <= byte_count + 16'd1;
            active     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
